// File: rtl/rcn_gpio_if.sv
// One 67-bit rcn ring word. The slave modport receives it and the master modport drives it.
interface rcn_gpio_if;
    logic [66:0] pkt;

    modport master (output pkt);
    modport slave  (input  pkt);
endinterface

// File: rtl/rcn_gpio.sv
// GPIO/status slave on the rcn ring: output bank, debounced input bank, edge flags and a maskable irq.
// Every ring word is delayed by exactly one register stage. Hits are turned into responses in the same slot.
module rcn_gpio #(
    parameter logic [31:0]     ADDR_BASE    = 32'hFFFFFF00,
    parameter int              OUT_W        = 5,
    parameter int              IN_W         = 4,
    parameter logic [IN_W-1:0] IN_INIT      = '0,
    parameter int              DEBOUNCE_CYC = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    rcn_gpio_if.slave        rcn_in,
    rcn_gpio_if.master       rcn_out,
    output logic [OUT_W-1:0] gpio_out,
    input  logic [IN_W-1:0]  gpio_in,
    output logic             irq
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [31:0]     ID_WORD  = {8'h47, 8'(OUT_W), 8'(IN_W), 8'h01};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [31:0] m);
        return (old & ~m) | (wd & m);
    endfunction

    function automatic logic [31:0] set_bits(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [31:0] m);
        return old | (wd & m);
    endfunction

    function automatic logic [31:0] clr_bits(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [31:0] m);
        return old & ~(wd & m);
    endfunction

    logic [66:0]      req_p0;
    logic             hit_p0;
    logic             wr_p0;
    logic [5:0]       off_p0;
    logic [31:0]      wdata_p0;
    logic [31:0]      bmask_p0;
    logic [31:0]      rdata_p0;
    logic [31:0]      en_word;

    logic [IN_W-1:0]  sync_p0, sync_p1;
    logic [IN_W-1:0]  in_q, in_nxt;
    logic [CNT_W-1:0] cnt_q   [IN_W];
    logic [CNT_W-1:0] cnt_nxt [IN_W];
    logic [IN_W-1:0]  rise_q, fall_q;
    logic [IN_W-1:0]  en_rise_q, en_fall_q;

    // Request decode: stage p0 is the word currently on rcn_in
    assign req_p0   = rcn_in.pkt;
    assign hit_p0   = req_p0[66] & req_p0[65] & (req_p0[53:38] == ADDR_BASE[23:8]);
    assign wr_p0    = hit_p0 & req_p0[64];
    assign off_p0   = req_p0[37:32];
    assign wdata_p0 = req_p0[31:0];
    assign bmask_p0 = {{8{req_p0[57]}}, {8{req_p0[56]}}, {8{req_p0[55]}}, {8{req_p0[54]}}};
    assign en_word  = 32'(en_rise_q) | (32'(en_fall_q) << 16);

    always_comb begin
        rdata_p0 = '0;
        case (off_p0)
            6'd0:    rdata_p0 = 32'(gpio_out);
            6'd3:    rdata_p0 = 32'(in_q);
            6'd4:    rdata_p0 = 32'(rise_q);
            6'd5:    rdata_p0 = 32'(fall_q);
            6'd6:    rdata_p0 = en_word;
            6'd7:    rdata_p0 = ID_WORD;
            default: rdata_p0 = '0;
        endcase
    end

    // A bit flips only after DEBOUNCE_CYC consecutive cycles of disagreement with the synchronised input
    always_comb begin
        in_nxt  = in_q;
        cnt_nxt = cnt_q;
        for (int i = 0; i < IN_W; i++) begin
            if (sync_p1[i] == in_q[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_nxt[i] = '0;
                in_nxt[i]  = ~in_q[i];
            end else begin
                cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcn_out.pkt <= '0;
            gpio_out    <= '0;
            irq         <= 1'b0;
            rise_q      <= '0;
            fall_q      <= '0;
            en_rise_q   <= '0;
            en_fall_q   <= '0;
            in_q        <= IN_INIT;
            sync_p0     <= IN_INIT;
            sync_p1     <= IN_INIT;
            for (int i = 0; i < IN_W; i++) cnt_q[i] <= '0;
        end else begin
            rcn_out.pkt <= hit_p0 ? {2'b10, req_p0[64:32], req_p0[64] ? wdata_p0 : rdata_p0}
                                  : req_p0;

            if (wr_p0 && off_p0 == 6'd0)
                gpio_out <= OUT_W'(merge(32'(gpio_out), wdata_p0, bmask_p0));
            else if (wr_p0 && off_p0 == 6'd1)
                gpio_out <= OUT_W'(set_bits(32'(gpio_out), wdata_p0, bmask_p0));
            else if (wr_p0 && off_p0 == 6'd2)
                gpio_out <= OUT_W'(clr_bits(32'(gpio_out), wdata_p0, bmask_p0));

            if (wr_p0 && off_p0 == 6'd6) begin
                en_rise_q <= IN_W'(merge(en_word, wdata_p0, bmask_p0));
                en_fall_q <= IN_W'(merge(en_word, wdata_p0, bmask_p0) >> 16);
            end

            sync_p0 <= gpio_in;
            sync_p1 <= sync_p0;
            in_q    <= in_nxt;
            cnt_q   <= cnt_nxt;

            // Edge set is ORed in after the clear so a simultaneous edge wins over W1C
            rise_q <= ((wr_p0 && off_p0 == 6'd4) ? IN_W'(clr_bits(32'(rise_q), wdata_p0, bmask_p0))
                                                 : rise_q) | (in_nxt & ~in_q);
            fall_q <= ((wr_p0 && off_p0 == 6'd5) ? IN_W'(clr_bits(32'(fall_q), wdata_p0, bmask_p0))
                                                 : fall_q) | (in_q & ~in_nxt);

            irq <= (|(rise_q & en_rise_q)) | (|(fall_q & en_fall_q));
        end
    end

endmodule

// File: tb/tb_rcn_gpio.sv
// Directed bench for rcn_gpio: register vector table, ring pass-through, debounce, irq and reset sequences.
module tb_rcn_gpio;
    localparam int OUT_W = 5;
    localparam int IN_W  = 4;
    localparam int DEB   = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [IN_W-1:0]  gpio_in = '0;
    logic [OUT_W-1:0] gpio_out;
    logic             irq;
    int               n_tests = 0;
    int               n_fail  = 0;
    logic [5:0]       tag = '0;

    rcn_gpio_if ring_in ();
    rcn_gpio_if ring_out ();

    rcn_gpio #(.OUT_W(OUT_W), .IN_W(IN_W), .DEBOUNCE_CYC(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .rcn_in(ring_in), .rcn_out(ring_out),
        .gpio_out(gpio_out), .gpio_in(gpio_in), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [5:0]  widx;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic [4:0]  exp_gpio;
    } vec_t;

    vec_t vecs[19];
    logic [66:0] pt_in[6];
    logic [66:0] pt_exp[6];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [21:0] reg_addr(input logic [5:0] widx);
        return {16'hFFFF, widx};
    endfunction

    function automatic logic [66:0] mkreq(input logic wr, input logic [5:0] id, input logic [3:0] m,
                                          input logic [21:0] a, input logic [31:0] d);
        return {1'b1, 1'b1, wr, id, m, a, d};
    endfunction

    function automatic logic [66:0] mkrsp(input logic wr, input logic [5:0] id, input logic [3:0] m,
                                          input logic [21:0] a, input logic [31:0] d);
        return {1'b1, 1'b0, wr, id, m, a, d};
    endfunction

    // One request on the ring; the response must be in the very next slot
    task automatic xact(input string name, input logic wr, input logic [5:0] widx, input logic [3:0] m,
                        input logic [31:0] d, input logic [31:0] exp_d);
        tag = tag + 6'd1;
        ring_in.pkt = mkreq(wr, tag, m, reg_addr(widx), d);
        step(1);
        check(name, ring_out.pkt, mkrsp(wr, tag, m, reg_addr(widx), exp_d));
        ring_in.pkt = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 6'h00, 4'b0001, 32'hAAAA_AA15, 32'hAAAA_AA15, 5'h15};
        vecs[1]  = '{1'b1, 6'h01, 4'b1111, 32'h0000_0002, 32'h0000_0002, 5'h17};
        vecs[2]  = '{1'b1, 6'h02, 4'b1111, 32'h0000_0004, 32'h0000_0004, 5'h13};
        vecs[3]  = '{1'b0, 6'h00, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0013, 5'h13};
        vecs[4]  = '{1'b0, 6'h01, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 5'h13};
        vecs[5]  = '{1'b0, 6'h02, 4'b1111, 32'h1234_5678, 32'h0000_0000, 5'h13};
        vecs[6]  = '{1'b0, 6'h07, 4'b1111, 32'h0000_0000, 32'h4705_0401, 5'h13};
        vecs[7]  = '{1'b0, 6'h03, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000, 5'h13};
        vecs[8]  = '{1'b1, 6'h10, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h13};
        vecs[9]  = '{1'b0, 6'h10, 4'b1111, 32'h5555_5555, 32'h0000_0000, 5'h13};
        vecs[10] = '{1'b1, 6'h00, 4'b1111, 32'hFFFF_FFE0, 32'hFFFF_FFE0, 5'h00};
        vecs[11] = '{1'b0, 6'h00, 4'b1111, 32'h0000_0000, 32'h0000_0000, 5'h00};
        vecs[12] = '{1'b1, 6'h00, 4'b0000, 32'h0000_001F, 32'h0000_001F, 5'h00};
        vecs[13] = '{1'b1, 6'h00, 4'b0001, 32'h0000_000A, 32'h0000_000A, 5'h0A};
        vecs[14] = '{1'b1, 6'h06, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h0A};
        vecs[15] = '{1'b0, 6'h06, 4'b1111, 32'h0000_0000, 32'h000F_000F, 5'h0A};
        vecs[16] = '{1'b1, 6'h06, 4'b1111, 32'h0000_0000, 32'h0000_0000, 5'h0A};
        vecs[17] = '{1'b0, 6'h04, 4'b1111, 32'h0000_0000, 32'h0000_0000, 5'h0A};
        vecs[18] = '{1'b0, 6'h05, 4'b1111, 32'h0000_0000, 32'h0000_0000, 5'h0A};

        pt_in[0]  = mkreq(1'b0, 6'h21, 4'hF, reg_addr(6'h07), 32'h0);
        pt_exp[0] = mkrsp(1'b0, 6'h21, 4'hF, reg_addr(6'h07), 32'h4705_0401);
        pt_in[1]  = mkreq(1'b1, 6'h22, 4'hF, 22'h000040, 32'h1234_5678);
        pt_exp[1] = pt_in[1];
        pt_in[2]  = mkrsp(1'b0, 6'h23, 4'hF, reg_addr(6'h00), 32'hCAFE_F00D);
        pt_exp[2] = pt_in[2];
        pt_in[3]  = mkreq(1'b1, 6'h24, 4'b0001, reg_addr(6'h01), 32'h1);
        pt_exp[3] = mkrsp(1'b1, 6'h24, 4'b0001, reg_addr(6'h01), 32'h1);
        pt_in[4]  = mkreq(1'b0, 6'h25, 4'hF, reg_addr(6'h00), 32'h0);
        pt_exp[4] = mkrsp(1'b0, 6'h25, 4'hF, reg_addr(6'h00), 32'h0000_000B);
        pt_in[5]  = '0;
        pt_exp[5] = '0;

        ring_in.pkt = '0;

        // Reset and idle
        step(2);
        check("reset_rcn_out", ring_out.pkt, 67'h0);
        check("reset_gpio", 67'(gpio_out), 67'h0);
        check("reset_irq", 67'(irq), 67'h0);
        rst_n = 1'b1;
        step(3);
        check("idle_rcn_out", ring_out.pkt, 67'h0);
        check("idle_irq", 67'(irq), 67'h0);

        // Register table
        for (int i = 0; i < 19; i++) begin
            xact($sformatf("vec%0d_rsp", i), vecs[i].wr, vecs[i].widx, vecs[i].mask,
                 vecs[i].wdata, vecs[i].exp_data);
            check($sformatf("vec%0d_gpio", i), 67'(gpio_out), 67'(vecs[i].exp_gpio));
            check($sformatf("vec%0d_irq", i), 67'(irq), 67'h0);
        end

        // Back-to-back stream mixing hits, a foreign request, a foreign response and an empty slot
        for (int i = 0; i < 6; i++) begin
            ring_in.pkt = pt_in[i];
            step(1);
            check($sformatf("pass%0d", i), ring_out.pkt, pt_exp[i]);
        end
        check("pass_gpio", 67'(gpio_out), 67'h0B);

        // Debounce: short glitch rejected
        gpio_in = 4'h1;
        step(5);
        gpio_in = 4'h0;
        step(20);
        xact("glitch_in", 1'b0, 6'h03, 4'hF, 32'h0, 32'h0);
        xact("glitch_rise", 1'b0, 6'h04, 4'hF, 32'h0, 32'h0);

        // Debounce: stable level accepted, then released
        gpio_in = 4'h1;
        step(12);
        xact("hold_in", 1'b0, 6'h03, 4'hF, 32'h0, 32'h1);
        xact("hold_rise", 1'b0, 6'h04, 4'hF, 32'h0, 32'h1);
        gpio_in = 4'h0;
        step(12);
        xact("release_fall", 1'b0, 6'h05, 4'hF, 32'h0, 32'h1);
        xact("release_in", 1'b0, 6'h03, 4'hF, 32'h0, 32'h0);

        // Interrupt: clear flags, enable rise on bit 0
        xact("clr_rise", 1'b1, 6'h04, 4'hF, 32'hF, 32'hF);
        xact("clr_fall", 1'b1, 6'h05, 4'hF, 32'hF, 32'hF);
        xact("rise_cleared", 1'b0, 6'h04, 4'hF, 32'h0, 32'h0);
        xact("en_rise0", 1'b1, 6'h06, 4'hF, 32'h1, 32'h1);
        step(1);
        check("irq_off", 67'(irq), 67'h0);
        gpio_in = 4'h1;
        step(12);
        check("irq_on_rise", 67'(irq), 67'h1);
        gpio_in = 4'h0;
        step(12);
        // New edge lands in the same cycle as a W1C of that bit
        gpio_in = 4'h1;
        step(9);
        xact("w1c_with_edge", 1'b1, 6'h04, 4'hF, 32'h1, 32'h1);
        step(2);
        check("irq_after_collision", 67'(irq), 67'h1);
        xact("rise_after_collision", 1'b0, 6'h04, 4'hF, 32'h0, 32'h1);
        xact("w1c_no_edge", 1'b1, 6'h04, 4'hF, 32'h1, 32'h1);
        check("irq_lag", 67'(irq), 67'h1);
        step(1);
        check("irq_cleared", 67'(irq), 67'h0);

        // Fall-enabled irq, then asynchronous reset in the middle of a burst
        xact("en_fall0", 1'b1, 6'h06, 4'hF, 32'h0001_0001, 32'h0001_0001);
        gpio_in = 4'h0;
        step(12);
        check("irq_on_fall", 67'(irq), 67'h1);
        ring_in.pkt = mkreq(1'b1, 6'h30, 4'hF, reg_addr(6'h00), 32'h1F);
        step(1);
        check("burst_gpio", 67'(gpio_out), 67'h1F);
        ring_in.pkt = mkreq(1'b0, 6'h31, 4'hF, reg_addr(6'h07), 32'h0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_rcn_out", ring_out.pkt, 67'h0);
        check("async_rst_gpio", 67'(gpio_out), 67'h0);
        check("async_rst_irq", 67'(irq), 67'h0);
        ring_in.pkt = '0;
        step(2);
        rst_n = 1'b1;
        step(1);
        check("post_rst_rcn_out", ring_out.pkt, 67'h0);
        xact("post_rst_in", 1'b0, 6'h03, 4'hF, 32'h0, 32'h0);
        xact("post_rst_en", 1'b0, 6'h06, 4'hF, 32'h0, 32'h0);
        xact("post_rst_fall", 1'b0, 6'h05, 4'hF, 32'h0, 32'h0);
        check("post_rst_irq", 67'(irq), 67'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
